// File: rtl/instr_mem_pkg.sv
// Shared word/byte constants and types for the instruction-memory responder
// and its program-load assembler.
package instr_mem_pkg;

  localparam int WORD_BITS      = 32;
  localparam int BYTES_PER_WORD = 4;

  // Returned for out-of-range fetches so the core executes a harmless word.
  localparam logic [WORD_BITS-1:0] NOP_WORD = 32'h0000_0000;

  typedef logic [1:0] lane_idx_t;

  localparam lane_idx_t LAST_LANE = lane_idx_t'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/instr_ld_assembler.sv
// Byte-serial program loader: packs little-endian bytes into words and hands
// each finished word to the array together with its sequential word index.
module instr_ld_assembler
  import instr_mem_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_clr_i,
  input  logic                 ld_en_i,
  input  logic [7:0]           ld_byte_i,
  output logic                 wr_en_o,
  output logic [ADDR_BITS-1:0] wr_idx_o,
  output logic [WORD_BITS-1:0] wr_word_o,
  output logic [ADDR_BITS:0]   ld_ptr_o,
  output logic                 ld_full_o
);

  lane_idx_t          byte_cnt_q, byte_cnt_d;
  logic [23:0]        partial_q, partial_d;
  logic [ADDR_BITS:0] ptr_q, ptr_d;
  logic               full;
  logic               accept;

  // The pointer never counts past the depth, so its MSB alone marks "full".
  assign full   = ptr_q[ADDR_BITS];
  assign accept = ld_en_i && !ld_clr_i && !full;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    partial_d  = partial_q;
    ptr_d      = ptr_q;
    wr_en_o    = 1'b0;
    wr_idx_o   = ptr_q[ADDR_BITS-1:0];
    wr_word_o  = {ld_byte_i, partial_q};

    if (ld_clr_i) begin
      byte_cnt_d = '0;
      partial_d  = '0;
      ptr_d      = '0;
    end else if (accept) begin
      if (byte_cnt_q == LAST_LANE) begin
        wr_en_o    = 1'b1;
        byte_cnt_d = '0;
        partial_d  = '0;
        ptr_d      = ptr_q + {{ADDR_BITS{1'b0}}, 1'b1};
      end else begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        case (byte_cnt_q)
          2'd0:    partial_d[7:0]   = ld_byte_i;
          2'd1:    partial_d[15:8]  = ld_byte_i;
          default: partial_d[23:16] = ld_byte_i;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      partial_q  <= '0;
      ptr_q      <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      partial_q  <= partial_d;
      ptr_q      <= ptr_d;
    end
  end

  assign ld_ptr_o  = ptr_q;
  assign ld_full_o = full;

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction memory serving fetch-stage word reads with a fixed latency and
// filled beforehand through the byte-serial program-load port.
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rd_en,
  input  logic [31:0]          i_addr,
  output logic [31:0]          o_data,
  output logic                 o_data_valid,
  input  logic                 i_ld_clr,
  input  logic                 i_ld_en,
  input  logic [7:0]           i_ld_byte,
  output logic [ADDR_BITS:0]   o_ld_ptr,
  output logic                 o_ld_full
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WORD_BITS-1:0] mem_q [DEPTH];

  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_idx;
  logic [WORD_BITS-1:0] wr_word;

  logic [ADDR_BITS-1:0] rd_idx;
  logic                 rd_in_range;
  logic [WORD_BITS-1:0] rd_word;
  logic                 unused_addr_lsbs;

  logic                 vld_q        [READ_LATENCY];
  logic [WORD_BITS-1:0] dat_q        [READ_LATENCY];
  logic                 stage_vld_in [READ_LATENCY];
  logic [WORD_BITS-1:0] stage_dat_in [READ_LATENCY];

  instr_ld_assembler #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ld_asm (
    .clk       (clk),
    .rst       (rst),
    .ld_clr_i  (i_ld_clr),
    .ld_en_i   (i_ld_en),
    .ld_byte_i (i_ld_byte),
    .wr_en_o   (wr_en),
    .wr_idx_o  (wr_idx),
    .wr_word_o (wr_word),
    .ld_ptr_o  (o_ld_ptr),
    .ld_full_o (o_ld_full)
  );

  // Word-aligned fetch: the byte offset within the word is meaningless here.
  assign unused_addr_lsbs = ^i_addr[1:0];
  assign rd_idx           = i_addr[ADDR_BITS+1:2];
  assign rd_in_range      = ~|i_addr[31:ADDR_BITS+2];
  assign rd_word          = rd_in_range ? mem_q[rd_idx] : NOP_WORD;

  // NOTE: the array has no reset; loaded programs survive rst and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_word;
    end
  end

  always_comb begin
    stage_vld_in[0] = i_rd_en;
    stage_dat_in[0] = rd_word;
    for (int i = 1; i < READ_LATENCY; i++) begin
      stage_vld_in[i] = vld_q[i-1];
      stage_dat_in[i] = dat_q[i-1];
    end
  end

  // Data only moves with a valid token, so the output holds its last response.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= NOP_WORD;
      end
    end else begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_q[i] <= stage_vld_in[i];
        if (stage_vld_in[i]) begin
          dat_q[i] <= stage_dat_in[i];
        end
      end
    end
  end

  assign o_data       = dat_q[READ_LATENCY-1];
  assign o_data_valid = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: two instances (deep/slow and tiny/fast) share
// one stimulus stream and are checked every cycle against a behavioural model.
module tb_instr_mem_responder;

  localparam int HIST = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic [31:0] addr;
  logic        ld_clr;
  logic        ld_en;
  logic [7:0]  ld_byte;

  logic [31:0] a_data, b_data;
  logic        a_vld, b_vld;
  logic [8:0]  a_ptr;
  logic [2:0]  b_ptr;
  logic        a_full, b_full;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  instr_mem_responder #(.ADDR_BITS(8), .READ_LATENCY(3)) dut_a (
    .clk(clk), .rst(rst), .i_rd_en(rd_en), .i_addr(addr),
    .o_data(a_data), .o_data_valid(a_vld),
    .i_ld_clr(ld_clr), .i_ld_en(ld_en), .i_ld_byte(ld_byte),
    .o_ld_ptr(a_ptr), .o_ld_full(a_full)
  );

  instr_mem_responder #(.ADDR_BITS(2), .READ_LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .i_rd_en(rd_en), .i_addr(addr),
    .o_data(b_data), .o_data_valid(b_vld),
    .i_ld_clr(ld_clr), .i_ld_en(ld_en), .i_ld_byte(ld_byte),
    .o_ld_ptr(b_ptr), .o_ld_full(b_full)
  );

  function automatic int abits_of(int d);
    return (d == 0) ? 8 : 2;
  endfunction

  function automatic int lat_of(int d);
    return (d == 0) ? 3 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem   [2][256];
  int          m_ptr   [2];
  int          m_cnt   [2];
  logic [7:0]  m_bytes [2][4];
  bit          req_v   [2][HIST];
  logic [31:0] req_d   [2][HIST];
  bit          exp_vld [2];
  logic [31:0] exp_data[2];
  int          cyc      = 0;
  int          last_rst = -1;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int depth;
      int abits;
      depth = 1 << abits_of(d);
      abits = abits_of(d);
      if (rst) begin
        req_v[d][cyc] = 1'b0;
        m_ptr[d] = 0;
        m_cnt[d] = 0;
      end else begin
        // The read sees the array as it was before this edge's commit.
        req_v[d][cyc] = rd_en;
        if ((addr >> (abits + 2)) == 0)
          req_d[d][cyc] = m_mem[d][(addr >> 2) & (depth - 1)];
        else
          req_d[d][cyc] = 32'h0;
        if (ld_clr) begin
          m_ptr[d] = 0;
          m_cnt[d] = 0;
        end else if (ld_en && m_ptr[d] < depth) begin
          m_bytes[d][m_cnt[d]] = ld_byte;
          m_cnt[d]++;
          if (m_cnt[d] == 4) begin
            m_mem[d][m_ptr[d]] = {m_bytes[d][3], m_bytes[d][2], m_bytes[d][1], m_bytes[d][0]};
            m_ptr[d]++;
            m_cnt[d] = 0;
          end
        end
      end
    end
    if (rst) last_rst = cyc;
    for (int d = 0; d < 2; d++) begin
      int k;
      k = cyc - lat_of(d) + 1;
      exp_vld[d] = (k >= 0) && (k > last_rst) && req_v[d][k];
      if (rst)             exp_data[d] = 32'h0;
      else if (exp_vld[d]) exp_data[d] = req_d[d][k];
    end
    if (cyc < HIST - 1) cyc++;
  end

  // ---------------- per-cycle compare and response capture ----------------
  logic [31:0] cap_a[$];
  logic [31:0] cap_b[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_valid", {31'b0, a_vld},  {31'b0, exp_vld[0]});
      check("a_data",  a_data,          exp_data[0]);
      check("a_ptr",   {23'b0, a_ptr},  32'(m_ptr[0]));
      check("a_full",  {31'b0, a_full}, {31'b0, (m_ptr[0] == 256)});
      check("b_valid", {31'b0, b_vld},  {31'b0, exp_vld[1]});
      check("b_data",  b_data,          exp_data[1]);
      check("b_ptr",   {29'b0, b_ptr},  32'(m_ptr[1]));
      check("b_full",  {31'b0, b_full}, {31'b0, (m_ptr[1] == 4)});
      if (a_vld) cap_a.push_back(a_data);
      if (b_vld) cap_b.push_back(b_data);
    end
  end

  task automatic check_cap(input string name, input int d, input logic [31:0] expq[$]);
    logic [31:0] got[$];
    if (d == 0) begin got = cap_a; cap_a = {}; end
    else        begin got = cap_b; cap_b = {}; end
    check({name, "_count"}, 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      if (i < got.size()) check(name, got[i], expq[i]);
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic rd, input logic [31:0] a,
                       input logic clr, input logic en, input logic [7:0] b);
    @(posedge clk);
    #1;
    rst = r; rd_en = rd; addr = a; ld_clr = clr; ld_en = en; ld_byte = b;
  endtask

  task automatic ld(input logic [7:0] b);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, b);
  endtask

  task automatic rd(input logic [31:0] a);
    drive(1'b0, 1'b1, a, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic clr();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [31:0] eq[$];
    rst = 1'b1; rd_en = 1'b0; addr = '0; ld_clr = 1'b0; ld_en = 1'b0; ld_byte = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    idle(1);

    // 1: two words loaded, then read back one at a time
    ld(8'h13); ld(8'h00); ld(8'h00); ld(8'h00);
    ld(8'hEF); ld(8'hBE); ld(8'hAD); ld(8'hDE);
    idle(1);
    check("t1_a_ptr", {23'b0, a_ptr}, 32'd2);
    check("t1_b_ptr", {29'b0, b_ptr}, 32'd2);
    check("t1_a_full", {31'b0, a_full}, 32'd0);
    rd(32'h0); rd(32'h4);
    idle(6);
    eq = {32'h0000_0013, 32'hDEAD_BEEF};
    check_cap("t1_a_resp", 0, eq);
    check_cap("t1_b_resp", 1, eq);

    // 2: back-to-back reads incl. unaligned and out-of-range
    rd(32'h0); rd(32'h4); rd(32'h3); rd(32'h400);
    idle(6);
    eq = {32'h0000_0013, 32'hDEAD_BEEF, 32'h0000_0013, 32'h0000_0000};
    check_cap("t2_a_resp", 0, eq);
    check_cap("t2_b_resp", 1, eq);

    // 3: partial word discarded by clear
    ld(8'hFF); ld(8'hEE); ld(8'hDD);
    clr();
    ld(8'h01); ld(8'h02); ld(8'h03); ld(8'h04);
    idle(1);
    check("t3_a_ptr", {23'b0, a_ptr}, 32'd1);
    rd(32'h0);
    idle(6);
    eq = {32'h0403_0201};
    check_cap("t3_a_resp", 0, eq);
    check_cap("t3_b_resp", 1, eq);

    // 4: fill the small memory, then overflow bytes must be ignored there
    clr();
    for (int i = 0; i < 16; i++) ld(8'(8'h10 + i));
    idle(1);
    check("t4_b_ptr", {29'b0, b_ptr}, 32'd4);
    check("t4_b_full", {31'b0, b_full}, 32'd1);
    check("t4_a_ptr", {23'b0, a_ptr}, 32'd4);
    ld(8'hA0); ld(8'hA1); ld(8'hA2); ld(8'hA3);
    idle(1);
    check("t4_b_ptr_after", {29'b0, b_ptr}, 32'd4);
    check("t4_b_full_after", {31'b0, b_full}, 32'd1);
    check("t4_a_ptr_after", {23'b0, a_ptr}, 32'd5);
    rd(32'h0); rd(32'hC);
    idle(6);
    eq = {32'h1312_1110, 32'h1F1E_1D1C};
    check_cap("t4_a_resp", 0, eq);
    check_cap("t4_b_resp", 1, eq);

    // 5: read and commit of the same word on one edge returns the old word
    clr();
    ld(8'h44); ld(8'h33); ld(8'h22); ld(8'h11);
    ld(8'h55); ld(8'h55); ld(8'h55); ld(8'h55);
    clr();
    ld(8'h44); ld(8'h33); ld(8'h22); ld(8'h11);
    ld(8'hAA); ld(8'hAA); ld(8'hAA);
    drive(1'b0, 1'b1, 32'h4, 1'b0, 1'b1, 8'hAA);
    rd(32'h4);
    idle(6);
    eq = {32'h5555_5555, 32'hAAAA_AAAA};
    check_cap("t5_a_resp", 0, eq);
    check_cap("t5_b_resp", 1, eq);

    // 6: reset one cycle after a read drops the in-flight response
    rd(32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    idle(1);
    check("t6_a_data", a_data, 32'h0);
    check("t6_b_data", b_data, 32'h0);
    check("t6_a_valid", {31'b0, a_vld}, 32'd0);
    check("t6_a_ptr", {23'b0, a_ptr}, 32'd0);
    check("t6_b_ptr", {29'b0, b_ptr}, 32'd0);
    idle(4);
    eq = {};
    check_cap("t6_a_drop", 0, eq);
    eq = {32'h1122_3344};
    check_cap("t6_b_early", 1, eq);
    rd(32'h4);
    idle(6);
    eq = {32'hAAAA_AAAA};
    check_cap("t6_a_kept", 0, eq);
    check_cap("t6_b_kept", 1, eq);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
